// File: rtl/seg7_readback_checker.sv
// Seven-segment readback checker: decodes four digit buses back to BCD and
// checks the displayed count increments by one. SEG_ACTIVE_HIGH_EN selects active-high pins.
`timescale 1ns/1ps

module seg7_bcd_dec (
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       ok
);
  always_comb begin
    ok    = 1'b1;
    digit = 4'd0;
    case (seg)
      7'h40: digit = 4'd0;
      7'h79: digit = 4'd1;
      7'h24: digit = 4'd2;
      7'h30: digit = 4'd3;
      7'h19: digit = 4'd4;
      7'h12: digit = 4'd5;
      7'h02: digit = 4'd6;
      7'h78: digit = 4'd7;
      7'h00: digit = 4'd8;
      7'h18: digit = 4'd9;
      default: ok = 1'b0;
    endcase
  end
endmodule

module seg7_readback_checker #(
  parameter int STABLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clkdiv,
  input  logic             rst,
  input  logic [6:0]       seg0,
  input  logic [6:0]       seg1,
  input  logic [6:0]       seg2,
  input  logic [6:0]       seg3,
  input  logic             clr_err,
  output logic [15:0]      bcd_out,
  output logic [13:0]      value_out,
  output logic             valid,
  output logic             locked,
  output logic             mismatch,
  output logic             bad_glyph,
  output logic [ERR_W-1:0] err_count
);
  localparam int NUM_DIG = 4;
  localparam int SEG_W   = 7;
  localparam int CW      = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  logic [NUM_DIG-1:0][SEG_W-1:0] seg_in, sync1, sync2, word_q, acc_word;
  logic [NUM_DIG-1:0][3:0]       dig;
  logic [NUM_DIG-1:0]            dig_ok;
  logic [CW-1:0]                 cnt, cnt_n;
  logic [CW:0]                   held;
  logic                          stable, accept, word_ok;
  logic [13:0]                   value_n, exp_val;
  state_t                        state, state_n;
  logic                          valid_n, mis_n, bad_n, upd, err_evt;
  logic [ERR_W-1:0]              err_n;

  // Internally everything is active-low so the decode table and blank value never change.
`ifdef SEG_ACTIVE_HIGH_EN
  assign seg_in = ~{seg3, seg2, seg1, seg0};
`else
  assign seg_in = {seg3, seg2, seg1, seg0};
`endif

  // held = cycles the synced word has been unchanged, including this one
  always_comb begin
    held    = (sync2 == word_q) ? ({1'b0, cnt} + (CW+1)'(1)) : (CW+1)'(1);
    stable  = held >= (CW+1)'(STABLE_CYCLES);
    cnt_n   = stable ? CW'(STABLE_CYCLES) : held[CW-1:0];
    accept  = stable && (sync2 != acc_word);
  end

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      word_q   <= '1;
      acc_word <= '1;
      cnt      <= '0;
    end else begin
      sync1  <= seg_in;
      sync2  <= sync1;
      word_q <= sync2;
      cnt    <= cnt_n;
      if (accept) acc_word <= sync2;
    end
  end

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    seg7_bcd_dec u_dec (
      .seg   (sync2[i]),
      .digit (dig[i]),
      .ok    (dig_ok[i])
    );
  end

  assign word_ok = &dig_ok;
  assign value_n = 14'(dig[3]) * 14'd1000 + 14'(dig[2]) * 14'd100
                 + 14'(dig[1]) * 14'd10 + 14'(dig[0]);
  assign exp_val = (value_out == 14'd9999) ? 14'd0 : value_out + 14'd1;

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    mis_n   = 1'b0;
    bad_n   = bad_glyph;
    upd     = 1'b0;
    if (accept) begin
      if (word_ok) begin
        valid_n = 1'b1;
        bad_n   = 1'b0;
        upd     = 1'b1;
        state_n = LOCKED;
        // A mismatch re-anchors on the new value rather than dropping lock.
        if (state == LOCKED && value_n != exp_val) mis_n = 1'b1;
      end else begin
        bad_n   = 1'b1;
        state_n = UNLOCKED;
      end
    end
    err_evt = mis_n || (accept && !word_ok);
    if (clr_err)
      err_n = err_evt ? ERR_W'(1) : '0;
    else if (err_evt && err_count != '1)
      err_n = err_count + ERR_W'(1);
    else
      err_n = err_count;
  end

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      mismatch  <= 1'b0;
      bad_glyph <= 1'b0;
      bcd_out   <= '0;
      value_out <= '0;
      err_count <= '0;
    end else begin
      valid     <= valid_n;
      mismatch  <= mis_n;
      bad_glyph <= bad_n;
      err_count <= err_n;
      if (upd) begin
        bcd_out   <= dig;
        value_out <= value_n;
      end
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_seg7_readback_checker.sv
// Scoreboard bench: stimulus pushes the expected response of each accepted
// word into a queue, a negedge monitor pops and compares on every DUT event.
`timescale 1ns/1ps

module tb_seg7_readback_checker;
  localparam int S    = 2;
  localparam int EW   = 2;
  localparam int EMAX = (1 << EW) - 1;
  localparam logic [27:0] BLANK = 28'hFFFFFFF;

  logic          clkdiv = 1'b0;
  logic          rst = 1'b0;
  logic          clr_err = 1'b0;
  logic [6:0]    seg0, seg1, seg2, seg3;
  logic [15:0]   bcd_out;
  logic [13:0]   value_out;
  logic          valid, locked, mismatch, bad_glyph;
  logic [EW-1:0] err_count;

  seg7_readback_checker #(.STABLE_CYCLES(S), .ERR_W(EW)) dut (
    .clkdiv(clkdiv), .rst(rst), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .clr_err(clr_err), .bcd_out(bcd_out), .value_out(value_out), .valid(valid),
    .locked(locked), .mismatch(mismatch), .bad_glyph(bad_glyph), .err_count(err_count)
  );

  initial forever #5 clkdiv = ~clkdiv;

  typedef struct {bit v; bit m; bit b; bit l; int val; int err; int cyc;} exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  // reference model state
  int          m_prev, m_err;
  bit          m_locked, m_bad;
  logic [27:0] m_acc, m_last_app;

  initial forever begin
    @(posedge clkdiv);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [27:0] enc_num(input int v);
    logic [27:0] w;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      w[i*7 +: 7] = tbl[x % 10];
      x = x / 10;
    end
    return w;
  endfunction

  function automatic bit is_code(input logic [6:0] c);
    for (int j = 0; j < 10; j++) if (tbl[j] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit dec_word(input logic [27:0] w, output int v);
    bit found;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      found = 1'b0;
      for (int j = 0; j < 10; j++)
        if (!found && tbl[j] == w[i*7 +: 7]) begin
          v = v * 10 + j;
          found = 1'b1;
        end
      if (!found) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic drive(input logic [27:0] w);
`ifdef SEG_ACTIVE_HIGH_EN
    {seg3, seg2, seg1, seg0} = ~w;
`else
    {seg3, seg2, seg1, seg0} = w;
`endif
  endtask

  task automatic model_reset();
    m_prev = 0; m_err = 0; m_locked = 0; m_bad = 0;
    m_acc = BLANK; m_last_app = BLANK;
  endtask

  // Present word w for 'hold' cycles; clr_evt pulses clr_err on the edge where its event lands.
  task automatic apply(input logic [27:0] w, input int hold, input bit clr_evt);
    exp_t e;
    int   v, n;
    bit   err_ev;
    drive(w);
    n = cyc;
    m_last_app = w;
    if (hold >= S && w != m_acc) begin
      m_acc = w;
      if (dec_word(w, v)) begin
        e.v = 1; e.b = 0; e.l = 1;
        e.m = m_locked && (v != ((m_prev == 9999) ? 0 : m_prev + 1));
        m_prev = v; m_locked = 1; m_bad = 0;
      end else begin
        e.v = 0; e.m = 0; e.b = 1; e.l = 0;
        m_locked = 0; m_bad = 1;
      end
      err_ev = e.m || e.b;
      if (clr_evt)                    m_err = err_ev ? 1 : 0;
      else if (err_ev && m_err < EMAX) m_err++;
      e.val = m_prev; e.err = m_err; e.cyc = n + 2 + S;
      q.push_back(e);
    end else if (clr_evt) begin
      m_err = 0;
    end
    for (int i = 0; i < hold; i++) begin
      clr_err = clr_evt && (i == S + 1);
      @(negedge clkdiv);
    end
    clr_err = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clkdiv);
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
    chk({tag, "_bad_glyph"}, int'(bad_glyph), 0);
    chk({tag, "_value_out"}, int'(value_out), 0);
    chk({tag, "_bcd_out"}, int'(bcd_out), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  // monitor
  initial begin
    exp_t e;
    bit   bad_q, ev;
    bad_q = 1'b0;
    forever begin
      @(negedge clkdiv);
      if (rst) begin
        bad_q = 1'b0;
      end else begin
        ev = valid || mismatch || (bad_glyph && !bad_q);
        bad_q = bad_glyph;
        if (ev) begin
          if (q.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("valid", int'(valid), int'(e.v));
            chk("mismatch", int'(mismatch), int'(e.m));
            chk("bad_glyph", int'(bad_glyph), int'(e.b));
            chk("locked", int'(locked), int'(e.l));
            chk("value_out", int'(value_out), e.val);
            chk("bcd_out", int'(bcd_out), to_bcd(e.val));
            chk("err_count", int'(err_count), e.err);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] w;
    logic [6:0]  c;
    int          r, hold, k;
    bit          clr;
    model_reset();
    drive(BLANK);
    #1 rst = 1'b1;
    repeat (3) @(negedge clkdiv);
    chk_zero("reset");
    rst = 1'b0;

    // first value after reset, then a clean run and the 9999 wrap
    apply(enc_num(0), 6, 0);
    for (int v = 1; v <= 12; v++) apply(enc_num(v), 3, 0);
    apply(enc_num(9998), 3, 0);
    apply(enc_num(9999), 3, 0);
    apply(enc_num(0), 3, 0);

    // skip by two, then resume
    apply(enc_num(5), 3, 0);
    apply(enc_num(7), 3, 0);
    apply(enc_num(8), 3, 0);

    // undecodable digit, then relock
    w = enc_num(123);
    w[14 +: 7] = 7'h2A;
    apply(w, 4, 0);
    apply(enc_num(456), 4, 0);

    // single-cycle glitch back to the held word: nothing accepted
    apply(enc_num(999), 1, 0);
    apply(enc_num(456), 4, 0);

    // reset while a new word is still stabilising
    drain();
    drive(enc_num(1234));
    @(negedge clkdiv);
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    drive(BLANK);
    model_reset();
    repeat (2) @(negedge clkdiv);
    rst = 1'b0;
    repeat (8) @(negedge clkdiv);

    // saturation, then clear coinciding with an error, then clear alone
    apply(enc_num(100), 4, 0);
    for (int i = 0; i < 5; i++) apply(enc_num((m_prev + 2) % 10000), 4, 0);
    apply(enc_num((m_prev + 2) % 10000), S + 3, 1);
    apply(enc_num((m_prev + 1) % 10000), S + 3, 1);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      r    = $urandom_range(0, 99);
      hold = $urandom_range(S, 5);
      if (r < 55) begin
        w = enc_num((m_prev + 1) % 10000);
      end else if (r < 70) begin
        w = enc_num($urandom_range(0, 9999));
      end else if (r < 80 && !m_bad) begin
        w = enc_num($urandom_range(0, 9999));
        k = $urandom_range(0, 3);
        c = 7'($urandom_range(0, 127));
        while (is_code(c)) c = 7'($urandom_range(0, 127));
        w[k*7 +: 7] = c;
      end else if (r < 90) begin
        w = enc_num($urandom_range(0, 9999));
        hold = 1;
      end else begin
        w = m_acc;
      end
      while (w == m_last_app) w = enc_num($urandom_range(0, 9999));
      clr = (hold >= S) && ($urandom_range(0, 9) == 0);
      if (clr) hold = S + 3;
      apply(w, hold, clr);
    end

    drain();
    repeat (6) @(negedge clkdiv);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
